// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared types and helpers for the multiply issue block:
//               the ARM multiply op encoding, the issue FSM state type,
//               the DSP latency and op-classification functions.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    typedef enum logic [2:0] {
        MUL_OP_MUL   = 3'd0,
        MUL_OP_MLA   = 3'd1,
        MUL_OP_UMULL = 3'd2,
        MUL_OP_SMULL = 3'd3,
        MUL_OP_UMLAL = 3'd4,
        MUL_OP_SMLAL = 3'd5
    } mul_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } mul_issue_state_t;

    localparam int MUL_DSP_LAT = 2;

    // Encodings 6 and 7 are not multiply ops.
    function automatic logic is_legal(input mul_op_t op);
        return (op <= MUL_OP_SMLAL);
    endfunction

    function automatic logic is_long(input mul_op_t op);
        case (op)
            MUL_OP_UMULL, MUL_OP_SMULL, MUL_OP_UMLAL, MUL_OP_SMLAL: return 1'b1;
            default:                                                return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed(input mul_op_t op);
        case (op)
            MUL_OP_SMULL, MUL_OP_SMLAL: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic is_acc(input mul_op_t op);
        case (op)
            MUL_OP_MLA, MUL_OP_UMLAL, MUL_OP_SMLAL: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    // Accumulator term added to the product: MLA only uses the low word.
    function automatic logic [63:0] acc_term(input mul_op_t op, input logic [63:0] acc);
        if (!is_acc(op)) begin
            return 64'd0;
        end else if (is_long(op)) begin
            return acc;
        end else begin
            return {32'd0, acc[31:0]};
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_mul.sv
`default_nettype none
// ============================================================================
// Module      : dsp_mul
// Description : Behavioural model of the 32x32->64 DSP multiply-accumulate
//               block: one operand register stage and one result register
//               stage, both gated by ena0, result = a*b + chainin (mod 2^64).
//   clock0/aclr0/ena0      : clock, async active-high clear, clock enable
//   dataa_0/datab_0        : operands
//   signa/signb            : operand signedness
//   chainin                : 64-bit addend
//   result                 : registered 64-bit result
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_mul (
    input  logic        clock0,
    input  logic        aclr0,
    input  logic        ena0,
    input  logic [31:0] dataa_0,
    input  logic [31:0] datab_0,
    input  logic        signa,
    input  logic        signb,
    input  logic [63:0] chainin,
    output logic [63:0] result
);

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_sa;
    logic        r_sb;
    logic [63:0] r_chain;
    logic [63:0] r_result;

    logic signed [32:0] w_a_ext;
    logic signed [32:0] w_b_ext;
    logic signed [65:0] w_prod;
    logic        [63:0] w_sum;

    // A 33rd bit carries either the sign or a zero so one signed multiplier
    // covers both signed and unsigned operands.
    assign w_a_ext = $signed({r_sa & r_a[31], r_a});
    assign w_b_ext = $signed({r_sb & r_b[31], r_b});
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_sum   = w_prod[63:0] + r_chain;

    always_ff @(posedge clock0 or posedge aclr0) begin
        if (aclr0) begin
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_chain  <= 64'd0;
            r_result <= 64'd0;
        end else if (ena0) begin
            r_a      <= dataa_0;
            r_b      <= datab_0;
            r_sa     <= signa;
            r_sb     <= signb;
            r_chain  <= chainin;
            r_result <= w_sum;
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: rtl/mul_flags.sv
`default_nettype none
// ============================================================================
// Module      : mul_flags
// Description : Combinational N/Z flag generation for a multiply result.
//               Short ops look at bits [31:0], long ops at the full 64 bits.
//   i_value   : 64-bit result
//   i_is_long : 1 = long (64-bit) op, 0 = short (32-bit) op
//   o_n       : negative flag
//   o_z       : zero flag
// Revision    : 1.0 - initial release
// ============================================================================
module mul_flags (
    input  logic [63:0] i_value,
    input  logic        i_is_long,
    output logic        o_n,
    output logic        o_z
);

    always_comb begin
        o_n = 1'b0;
        o_z = 1'b0;
        if (i_is_long) begin
            o_n = i_value[63];
            o_z = (i_value == 64'd0);
        end else begin
            o_n = i_value[31];
            o_z = (i_value[31:0] == 32'd0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_issue.sv
`default_nettype none
// ============================================================================
// Module      : mul_issue
// Description : Initiator side of the DSP multiply-accumulate interface.
//               Accepts one ARM multiply op at a time over req valid/ready,
//               drives the DSP for DSP_LAT enabled edges, then returns the
//               64-bit result with N/Z flags over rsp valid/ready.
//   clk, rst                     : clock, async active-high reset
//   req_valid/ready/op/a/b/acc   : request channel
//   rsp_valid/ready/result/n/z   : response channel
//   dsp_dataa/datab/signa/signb  : DSP operands and signedness
//   dsp_ena/dsp_chainin          : DSP clock enable and addend
//   dsp_result                   : DSP registered result
// Build option: MUL_ISSUE_EARLY_ZERO_EN - a zero operand bypasses the DSP
//               and answers with the accumulator term one cycle after accept.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_issue
    import mul_pkg::*;
#(
    parameter int DSP_LAT = MUL_DSP_LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  mul_op_t     req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [63:0] req_acc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_result,
    output logic        rsp_n,
    output logic        rsp_z,
    output logic [31:0] dsp_dataa,
    output logic [31:0] dsp_datab,
    output logic        dsp_signa,
    output logic        dsp_signb,
    output logic        dsp_ena,
    output logic [63:0] dsp_chainin,
    input  logic [63:0] dsp_result
);

    localparam int              c_CNT_W    = (DSP_LAT > 2) ? $clog2(DSP_LAT) : 1;
    // WAIT covers DSP_LAT-1 enabled edges; the counter runs down to zero.
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(DSP_LAT - 2);

    mul_issue_state_t   r_state, w_state_nxt;
    mul_op_t            r_op,    w_op_nxt;
    logic [31:0]        r_a,     w_a_nxt;
    logic [31:0]        r_b,     w_b_nxt;
    logic [63:0]        r_acc,   w_acc_nxt;
    logic               r_bypass, w_bypass_nxt;
    logic [c_CNT_W-1:0] r_cnt,   w_cnt_nxt;

    logic        w_early;
    logic [63:0] w_bypass_val;
    logic [63:0] w_result;
    logic        w_n;
    logic        w_z;

`ifdef MUL_ISSUE_EARLY_ZERO_EN
    assign w_early = (req_a == 32'd0) || (req_b == 32'd0);
`else
    assign w_early = 1'b0;
`endif

    // Illegal ops answer zero; zero-operand shortcuts answer the addend.
    assign w_bypass_val = is_legal(r_op) ? acc_term(r_op, r_acc) : 64'd0;

    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_acc_nxt    = r_acc;
        w_bypass_nxt = r_bypass;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_op_nxt  = req_op;
                    w_a_nxt   = req_a;
                    w_b_nxt   = req_b;
                    w_acc_nxt = req_acc;
                    if (!is_legal(req_op) || w_early) begin
                        w_bypass_nxt = 1'b1;
                        w_state_nxt  = ST_DONE;
                    end else begin
                        w_bypass_nxt = 1'b0;
                        w_state_nxt  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                w_cnt_nxt   = c_CNT_LOAD;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op     <= MUL_OP_MUL;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_acc    <= 64'd0;
            r_bypass <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_acc    <= w_acc_nxt;
            r_bypass <= w_bypass_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // The DSP result register is the response data register: dsp_ena is low
    // in DONE, so the value stays stable until the core takes it.
    always_comb begin
        w_result = 64'd0;
        if (r_state == ST_DONE) begin
            if (r_bypass) begin
                w_result = w_bypass_val;
            end else if (is_long(r_op)) begin
                w_result = dsp_result;
            end else begin
                w_result = {32'd0, dsp_result[31:0]};
            end
        end
    end

    mul_flags u_flags (
        .i_value   (w_result),
        .i_is_long (is_long(r_op)),
        .o_n       (w_n),
        .o_z       (w_z)
    );

    assign req_ready   = (r_state == ST_IDLE);
    assign rsp_valid   = (r_state == ST_DONE);
    assign rsp_result  = w_result;
    assign rsp_n       = rsp_valid & w_n;
    assign rsp_z       = rsp_valid & w_z;

    assign dsp_ena     = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign dsp_dataa   = r_a;
    assign dsp_datab   = r_b;
    assign dsp_signa   = is_signed(r_op);
    assign dsp_signb   = is_signed(r_op);
    assign dsp_chainin = acc_term(r_op, r_acc);

endmodule
`default_nettype wire

// File: tb/tb_mul_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_issue
// Description : Self-checking bench for mul_issue driving the dsp_mul model.
//               Table of directed ops plus stall and mid-op reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_issue;
    import mul_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    mul_op_t     req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [63:0] req_acc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic        rsp_n;
    logic        rsp_z;
    logic [31:0] dsp_dataa;
    logic [31:0] dsp_datab;
    logic        dsp_signa;
    logic        dsp_signb;
    logic        dsp_ena;
    logic [63:0] dsp_chainin;
    logic [63:0] dsp_result;

    always #5 clk = ~clk;

    mul_issue u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_acc    (req_acc),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_n      (rsp_n),
        .rsp_z      (rsp_z),
        .dsp_dataa  (dsp_dataa),
        .dsp_datab  (dsp_datab),
        .dsp_signa  (dsp_signa),
        .dsp_signb  (dsp_signb),
        .dsp_ena    (dsp_ena),
        .dsp_chainin(dsp_chainin),
        .dsp_result (dsp_result)
    );

    dsp_mul u_dsp (
        .clock0  (clk),
        .aclr0   (rst),
        .ena0    (dsp_ena),
        .dataa_0 (dsp_dataa),
        .datab_0 (dsp_datab),
        .signa   (dsp_signa),
        .signb   (dsp_signb),
        .chainin (dsp_chainin),
        .result  (dsp_result)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] acc;
        logic [63:0] res;
        logic        n;
        logic        z;
        int          lat;
    } vec_t;

    localparam int c_NVEC = 12;
`ifdef MUL_ISSUE_EARLY_ZERO_EN
    localparam int c_ZLAT = 1;
`else
    localparam int c_ZLAT = 3;
`endif

    vec_t vecs [c_NVEC];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one op, accept it, and return the number of cycles until
    // rsp_valid (0 on timeout) and how many of those cycles had dsp_ena high.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] acc, output int lat, output int ena_cnt);
        @(negedge clk);
        check("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_op    = mul_op_t'(op);
        req_a     = a;
        req_b     = b;
        req_acc   = acc;
        @(posedge clk);
        lat     = 0;
        ena_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) begin
                lat = c;
                break;
            end
            ena_cnt += int'(dsp_ena);
        end
    endtask

    task automatic release_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_valid_drop"}, {63'd0, rsp_valid}, 64'd0);
        check({tag, "_ready_back"}, {63'd0, req_ready}, 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    lat;
        int    ena_cnt;
        string tag;
        tag = $sformatf("v%0d", idx);
        issue(v.op, v.a, v.b, v.acc, lat, ena_cnt);
        check({tag, "_latency"}, 64'(lat), 64'(v.lat));
        check({tag, "_result"}, rsp_result, v.res);
        check({tag, "_n"}, {63'd0, rsp_n}, {63'd0, v.n});
        check({tag, "_z"}, {63'd0, rsp_z}, {63'd0, v.z});
        check({tag, "_ena_cycles"}, 64'(ena_cnt), 64'(v.lat - 1));
        check({tag, "_done_ena_rdy"}, {62'd0, dsp_ena, req_ready}, 64'd0);
        release_rsp(tag);
    endtask

    initial begin
        int  lat;
        int  ena_cnt;
        logic seen;

        vecs[0]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0, 3};
        vecs[1]  = '{3'd5, 32'hFFFF_FFFE, 32'd3, 64'd10, 64'd4, 1'b0, 1'b0, 3};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 3};
        vecs[3]  = '{3'd1, 32'h8000_0000, 32'd2, 64'hDEAD_0000_0000_0001, 64'd1, 1'b0, 1'b0, 3};
        vecs[4]  = '{3'd0, 32'h0001_0000, 32'h0001_0000, 64'd0, 64'd0, 1'b0, 1'b1, 3};
        vecs[5]  = '{3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'hFFFF_FFFE_0000_0000, 1'b1, 1'b0, 3};
        vecs[6]  = '{3'd0, 32'h0000_FFFF, 32'h0001_0001, 64'd0, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 3};
        vecs[7]  = '{3'd6, 32'd5, 32'd5, 64'd7, 64'd0, 1'b0, 1'b1, 1};
        vecs[8]  = '{3'd4, 32'd0, 32'd9, 64'h1_0000_0000, 64'h1_0000_0000, 1'b0, 1'b0, c_ZLAT};
        vecs[9]  = '{3'd3, 32'h8000_0000, 32'h8000_0000, 64'd0, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 3};
        vecs[10] = '{3'd1, 32'd3, 32'd0, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000, 1'b1, 1'b0, c_ZLAT};
        vecs[11] = '{3'd7, 32'd1, 32'd1, 64'd1, 64'd0, 1'b0, 1'b1, 1};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = MUL_OP_MUL;
        req_a     = 32'd0;
        req_b     = 32'd0;
        req_acc   = 64'd0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_ready", {63'd0, req_ready}, 64'd1);
        check("reset_rsp_flags", {61'd0, rsp_valid, rsp_n, rsp_z}, 64'd0);
        check("reset_result", rsp_result, 64'd0);
        check("reset_dsp_ena", {63'd0, dsp_ena}, 64'd0);
        check("reset_dsp_data", {dsp_dataa, dsp_datab}, 64'd0);
        check("reset_dsp_chain", dsp_chainin, 64'd0);

        for (int i = 0; i < c_NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // Response back-pressure: output must hold while rsp_ready is low.
        issue(3'd0, 32'd5, 32'd7, 64'd0, lat, ena_cnt);
        check("stall_latency", 64'(lat), 64'd3);
        for (int c = 0; c < 10; c++) begin
            check("stall_ctl", {61'd0, rsp_valid, req_ready, dsp_ena}, 64'd4);
            check("stall_result", rsp_result, 64'd35);
            @(negedge clk);
        end
        release_rsp("stall");

        // Reset asserted while the DSP is mid-operation.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = MUL_OP_UMULL;
        req_a     = 32'd3;
        req_b     = 32'd4;
        req_acc   = 64'd0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("midrst_in_wait", {63'd0, dsp_ena}, 64'd1);
        rst = 1'b1;
        #2;
        check("midrst_idle", {63'd0, req_ready}, 64'd1);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        check("midrst_no_rsp", {63'd0, seen}, 64'd0);
        run_vec('{3'd0, 32'd2, 32'd3, 64'd0, 64'd6, 1'b0, 1'b0, 3}, 99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, expected completion before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
